// File: rtl/ram_arb_pkg.sv
// Shared types and default sizes for the two-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_DEPTH  = 256;

    // One access walks IDLE -> {RD|WR|ERR} -> DONE -> IDLE.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_ERR  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester A/B handshakes plus the RAM strobe/address side of the arbiter.
// Latency: n/a (wires only).
// Backpressure: a requester holds *_req until its *_ack pulse.
interface ram_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;
    logic              a_ack;
    logic              a_err;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_ack;
    logic              b_err;

    logic              ram_read;
    logic              ram_write;
    logic [ADDR_W-1:0] ram_addr;

    // Requester / RAM-model side.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_ack, a_err,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ack, b_err,
        input  ram_read, ram_write, ram_addr
    );

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_ack, a_err,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ack, b_err,
        output ram_read, ram_write, ram_addr
    );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; pointer names the side that wins a tie.
// Latency: grant is combinational; pointer updates on the advance edge.
// Backpressure: pointer only moves when an access is actually started.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_advance,
    output logic o_gnt_b
);
    logic r_ptr_b;

    // Lone requester wins outright; on a tie the pointer decides.
    always_comb begin
        o_gnt_b = (i_req_a && i_req_b) ? r_ptr_b : i_req_b;
    end

    // Hand priority to the loser of the grant just taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_b <= 1'b0;
        end else if (i_advance) begin
            r_ptr_b <= ~o_gnt_b;
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one tri-state RAM between ports A and B, one access at a time.
// Latency: req sampled in IDLE -> ack two edges later; 3 cycles per access.
// Backpressure: losing port waits at most one access; req held until ack.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    ram_port_arbiter_if.slave bus,
    inout  wire  [DATA_W-1:0] ram_data
);
    state_t            r_state;
    logic              r_owner_b;
    logic              r_ram_read;
    logic              r_ram_write;
    logic              r_drive;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_a_ack;
    logic              r_b_ack;
    logic              r_a_err;
    logic              r_b_err;

    logic              w_start;
    logic              w_gnt_b;
    logic              w_sel_we;
    logic              w_sel_oor;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_start = (r_state == ST_IDLE) && (bus.a_req || bus.b_req);

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (reset),
        .i_req_a   (bus.a_req),
        .i_req_b   (bus.b_req),
        .i_advance (w_start),
        .o_gnt_b   (w_gnt_b)
    );

    // Mux the winning requester's command; flag addresses beyond the RAM.
    always_comb begin
        w_sel_we    = w_gnt_b ? bus.b_we    : bus.a_we;
        w_sel_addr  = w_gnt_b ? bus.b_addr  : bus.a_addr;
        w_sel_wdata = w_gnt_b ? bus.b_wdata : bus.a_wdata;
        w_sel_oor   = (int'(w_sel_addr) >= DEPTH);
    end

    // Access sequencer: all RAM strobes, bus enable and port results are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner_b   <= 1'b0;
            r_ram_read  <= 1'b0;
            r_ram_write <= 1'b0;
            r_drive     <= 1'b0;
            r_ram_addr  <= '0;
            r_wdata     <= '0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
            r_a_ack     <= 1'b0;
            r_b_ack     <= 1'b0;
            r_a_err     <= 1'b0;
            r_b_err     <= 1'b0;
        end else begin
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_a_err <= 1'b0;
            r_b_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_drive <= 1'b0;
                    if (w_start) begin
                        r_owner_b  <= w_gnt_b;
                        r_ram_addr <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        if (w_sel_oor) begin
                            r_state <= ST_ERR;
                        end else if (w_sel_we) begin
                            r_state     <= ST_WR;
                            r_ram_write <= 1'b1;
                            r_drive     <= 1'b1;
                        end else begin
                            r_state    <= ST_RD;
                            r_ram_read <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    r_ram_read <= 1'b0;
                    if (r_owner_b) begin
                        r_b_rdata <= ram_data;
                        r_b_ack   <= 1'b1;
                    end else begin
                        r_a_rdata <= ram_data;
                        r_a_ack   <= 1'b1;
                    end
                    r_state <= ST_DONE;
                end
                ST_WR: begin
                    // Bus stays driven into DONE for RAM hold time.
                    r_ram_write <= 1'b0;
                    r_a_ack     <= ~r_owner_b;
                    r_b_ack     <= r_owner_b;
                    r_state     <= ST_DONE;
                end
                ST_ERR: begin
                    r_a_ack <= ~r_owner_b;
                    r_b_ack <= r_owner_b;
                    r_a_err <= ~r_owner_b;
                    r_b_err <= r_owner_b;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_drive <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_ram_read  <= 1'b0;
                    r_ram_write <= 1'b0;
                    r_drive     <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram_data      = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign bus.ram_read  = r_ram_read;
    assign bus.ram_write = r_ram_write;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.a_rdata   = r_a_rdata;
    assign bus.a_ack     = r_a_ack;
    assign bus.a_err     = r_a_err;
    assign bus.b_rdata   = r_b_rdata;
    assign bus.b_ack     = r_b_ack;
    assign bus.b_err     = r_b_err;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural tri-state RAM.
// Latency: n/a.
// Backpressure: n/a.
module tb_ram_port_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    wire [31:0] ram_data;
    logic       mon_en = 1'b0;

    ram_port_arbiter_if #(.DATA_W(32), .ADDR_W(9)) bus ();

    ram_port_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    // RAM model: drives the bus only while read is strobed.
    logic [31:0] mem [0:511];
    assign ram_data = bus.ram_read ? mem[bus.ram_addr] : 32'bz;
    always @(posedge clk) if (bus.ram_write) mem[bus.ram_addr] <= ram_data;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus-safety checks every cycle outside reset.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("no_rd_wr_overlap", 64'(bus.ram_read & bus.ram_write), 64'd0);
            chk("no_drive_during_rd", 64'(bus.ram_read & dut.r_drive), 64'd0);
        end
    end

    // One full access on a port; lat = ticks from request to ack (0 = no ack within the window).
    task automatic access(input bit pb, input bit we, input logic [8:0] addr,
                          input logic [31:0] wd, output int lat,
                          output logic [31:0] rd, output logic er);
        lat = 0; rd = '0; er = 1'b0;
        if (pb) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
        end
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (pb ? bus.b_ack : bus.a_ack) begin
                lat = i;
                rd  = pb ? bus.b_rdata : bus.a_rdata;
                er  = pb ? bus.b_err : bus.a_err;
                break;
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick();
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic        exp_b;
    int          wait_n;
    bit          got;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        reset = 1'b1;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ram_read", 64'(bus.ram_read), 64'd0);
        chk("rst_ram_write", 64'(bus.ram_write), 64'd0);
        chk("rst_ram_addr", 64'(bus.ram_addr), 64'd0);
        chk("rst_a_ack", 64'(bus.a_ack), 64'd0);
        chk("rst_a_rdata", 64'(bus.a_rdata), 64'd0);
        chk("rst_b_err", 64'(bus.b_err), 64'd0);
        chk("rst_drive", 64'(dut.r_drive), 64'd0);
        chk("rst_ptr", 64'(dut.u_arb.r_ptr_b), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // A writes 0x00800055 to addr 0, step by step
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 9'd0; bus.a_wdata = 32'h0080_0055;
        tick();
        chk("wr_strobe", 64'(bus.ram_write), 64'd1);
        chk("wr_addr", 64'(bus.ram_addr), 64'd0);
        chk("wr_bus_data", 64'(ram_data), 64'h0080_0055);
        chk("wr_no_early_ack", 64'(bus.a_ack), 64'd0);
        tick();
        chk("wr_ack", 64'(bus.a_ack), 64'd1);
        chk("wr_done_strobe_low", 64'(bus.ram_write), 64'd0);
        chk("wr_done_bus_held", 64'(ram_data), 64'h0080_0055);
        bus.a_req = 1'b0;
        tick();
        chk("wr_ack_pulse_ends", 64'(bus.a_ack), 64'd0);
        chk("wr_bus_released", 64'(dut.r_drive), 64'd0);
        chk("wr_mem", 64'(mem[0]), 64'h0080_0055);

        // A reads addr 0 back
        access(1'b0, 1'b0, 9'd0, 32'h0, lat, rd, er);
        chk("rd_latency", 64'(lat), 64'd2);
        chk("rd_data", 64'(rd), 64'h0080_0055);
        chk("rd_err", 64'(er), 64'd0);

        // Fresh pointer, then A read 85 and B write 85 in the same cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 9'd85;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 9'd85; bus.b_wdata = 32'h2;
        tick();
        chk("tie_a_read_first", 64'(bus.ram_read), 64'd1);
        chk("tie_a_addr", 64'(bus.ram_addr), 64'd85);
        tick();
        chk("tie_a_ack", 64'(bus.a_ack), 64'd1);
        chk("tie_b_not_yet", 64'(bus.b_ack), 64'd0);
        chk("tie_a_rdata", 64'(bus.a_rdata), 64'd0);
        bus.a_req = 1'b0;
        tick();
        tick();
        chk("tie_b_write", 64'(bus.ram_write), 64'd1);
        chk("tie_b_bus", 64'(ram_data), 64'h2);
        tick();
        chk("tie_b_ack", 64'(bus.b_ack), 64'd1);
        chk("tie_ptr_back_to_a", 64'(dut.u_arb.r_ptr_b), 64'd0);
        bus.b_req = 1'b0;
        tick();
        access(1'b0, 1'b0, 9'd85, 32'h0, lat, rd, er);
        chk("tie_readback", 64'(rd), 64'h2);

        // B reads out-of-range 0x100: error, no strobes, port A untouched
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 9'h100;
        tick();
        chk("oor_no_strobes", 64'({bus.ram_read, bus.ram_write}), 64'd0);
        tick();
        chk("oor_b_ack", 64'(bus.b_ack), 64'd1);
        chk("oor_b_err", 64'(bus.b_err), 64'd1);
        chk("oor_a_quiet", 64'({bus.a_ack, bus.a_err}), 64'd0);
        chk("oor_a_rdata_kept", 64'(bus.a_rdata), 64'h2);
        bus.b_req = 1'b0;
        tick();
        access(1'b0, 1'b0, 9'd255, 32'h0, lat, rd, er);
        chk("edge_255_latency", 64'(lat), 64'd2);
        chk("edge_255_no_err", 64'(er), 64'd0);

        // Both hold requests: pointer is B (A won last), so B,A,B,... every 3 cycles
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 9'd10; bus.a_wdata = 32'hA;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 9'd20;
        exp_b = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_n = 0;
            got = 1'b0;
            for (int i = 0; i < 6; i++) begin
                tick();
                wait_n++;
                if (bus.a_ack || bus.b_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("alt_ack_seen", 64'(got), 64'd1);
            chk("alt_port", 64'(bus.b_ack), 64'(exp_b));
            chk("alt_single_ack", 64'(bus.a_ack & bus.b_ack), 64'd0);
            if (k > 0) chk("alt_spacing", 64'(wait_n), 64'd3);
            exp_b = ~exp_b;
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        tick();
        access(1'b1, 1'b0, 9'd10, 32'h0, lat, rd, er);
        chk("alt_a_write_landed", 64'(rd), 64'hA);
        chk("pre_rst_ptr_is_a", 64'(dut.u_arb.r_ptr_b), 64'd0);
        access(1'b0, 1'b0, 9'd1, 32'h0, lat, rd, er);

        // Reset in the middle of a write
        chk("pre_rst_ptr_is_b", 64'(dut.u_arb.r_ptr_b), 64'd1);
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 9'd3; bus.a_wdata = 32'hDEAD;
        tick();
        chk("midrst_in_wr", 64'(bus.ram_write), 64'd1);
        #2;
        reset = 1'b1;
        bus.a_req = 1'b0;
        #1;
        chk("midrst_write_drop", 64'(bus.ram_write), 64'd0);
        chk("midrst_bus_released", 64'(dut.r_drive), 64'd0);
        chk("midrst_no_ack", 64'(bus.a_ack), 64'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_late_ack", 64'({bus.a_ack, bus.b_ack}), 64'd0);
        end
        chk("midrst_ptr_a", 64'(dut.u_arb.r_ptr_b), 64'd0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
